// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_cmd_sequencer                                             |
// | Purpose  : Initiator-side front end for an 8-bit combinational ALU.      |
// |            Accepts commands over valid/ready, drives registered ALU      |
// |            operands/opcode, captures the ALU result with status flags   |
// |            and returns it over a second valid/ready handshake. Keeps an  |
// |            accumulator so command streams can chain results.             |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_acc  command in    |
// |            alu_op/alu_a/alu_b (out), alu_result (in)      ALU interface |
// |            rsp_valid/rsp_ready/rsp_result/rsp_zero/rsp_neg/rsp_carry     |
// |            acc, op_count                                  status        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] acc,
  output logic [CNTW-1:0]  op_count
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             cmd_fire;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH:0]   sum_ext;
  logic             carry_sel;
  logic             carry_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // Carry/borrow is derived from the same operands handed to the ALU, since
  // the ALU itself only returns the modulo-2^WIDTH result.
  assign sel_a   = cmd_acc ? acc : cmd_a;
  assign sum_ext = {1'b0, sel_a} + {1'b0, cmd_b};

  always_comb begin
    carry_sel = 1'b0;
    if (cmd_op == OP_ADD)      carry_sel = sum_ext[WIDTH];
    else if (cmd_op == OP_SUB) carry_sel = (sel_a < cmd_b);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      carry_q    <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_carry  <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (cmd_fire) begin
        alu_op  <= cmd_op;
        alu_a   <= sel_a;
        alu_b   <= cmd_b;
        carry_q <= carry_sel;
      end
      // ALU inputs have been stable for the whole EXEC cycle here.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        acc        <= alu_result;
        rsp_zero   <= (alu_result == '0);
        rsp_neg    <= alu_result[WIDTH-1];
        rsp_carry  <= carry_q;
      end
      if (rsp_fire) op_count <= op_count + CNTW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_cmd_sequencer                                          |
// | Purpose  : Self-checking bench for alu_cmd_sequencer with a behavioural  |
// |            ALU and a response scoreboard. CNTW is reduced to 4 so the    |
// |            completed-operation counter wraps quickly.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic             cmd_acc;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_neg, rsp_carry;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  op_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_carry(rsp_carry),
    .acc(acc), .op_count(op_count)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = ~alu_a;
      3'd3: alu_result = alu_a & alu_b;
      3'd4: alu_result = alu_a | alu_b;
      3'd5: alu_result = ~(alu_a & alu_b);
      3'd6: alu_result = ~(alu_a | alu_b);
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       neg;
    logic       carry;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_acc = '0;
  logic [3:0] cnt_model = '0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] s;
    s       = {1'b0, a} + {1'b0, b};
    e.carry = 1'b0;
    case (op)
      3'd0: begin e.result = s[7:0]; e.carry = s[8]; end
      3'd1: begin e.result = a - b;  e.carry = (a < b); end
      3'd2: e.result = ~a;
      3'd3: e.result = a & b;
      3'd4: e.result = a | b;
      3'd5: e.result = ~(a & b);
      3'd6: e.result = ~(a | b);
      default: e.result = a ^ b;
    endcase
    e.zero = (e.result == 8'h00);
    e.neg  = e.result[7];
    return e;
  endfunction

  // Scoreboard: compare each response at the negedge before its handshake edge
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_result", 32'(rsp_result), 32'(e.result));
        check("rsp_zero",   32'(rsp_zero),   32'(e.zero));
        check("rsp_neg",    32'(rsp_neg),    32'(e.neg));
        check("rsp_carry",  32'(rsp_carry),  32'(e.carry));
        check("rsp_acc",    32'(acc),        32'(e.result));
        check("rsp_opcnt",  32'(op_count),   32'(cnt_model));
        cnt_model = cnt_model + 4'd1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = use_acc; cmd_valid = 1'b1;
    e = model(op, use_acc ? model_acc : a, b);
    if (expect_rsp) sb_q.push_back(e);
    model_acc = e.result;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(cmd_ready && sb_q.size() == 0) && n < 50);
    if (!(cmd_ready && sb_q.size() == 0)) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] held_res;
    logic [7:0] held_a;
    int         k;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_acc",       32'(acc),       32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_alu",       {alu_op, alu_a, alu_b}, 32'd0);
    check("rst_rsp",       {rsp_result, rsp_zero, rsp_neg, rsp_carry}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 0x7F+0x01 with latency check
    send(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1);
    check("lat_n1_valid", 32'(rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    check("add_acc",   32'(acc),      32'h80);
    check("add_count", 32'(op_count), 32'd1);

    // Boundary carry / borrow
    send(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1); wait_idle();
    send(3'd1, 8'h05, 8'h07, 1'b0, 1'b1); wait_idle();

    // Chaining through the accumulator
    send(3'd0, 8'h10, 8'h20, 1'b0, 1'b1); wait_idle();
    send(3'd7, 8'h00, 8'hFF, 1'b1, 1'b1);
    check("chain_alu_a", 32'(alu_a), 32'h30);
    wait_idle();
    check("chain_acc", 32'(acc), 32'hCF);

    // Backpressure: hold response for 5 cycles, poke ignored commands
    rsp_ready = 1'b0;
    send(3'd4, 8'h0F, 8'h30, 1'b0, 1'b1);
    held_a = alu_a;
    @(posedge clk); #1;
    held_res = rsp_result;
    check("bp_result_first", 32'(held_res), 32'h3F);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0]; cmd_op = 3'd2; cmd_a = 8'h55; cmd_b = 8'hAA; cmd_acc = 1'b0;
      @(posedge clk); #1;
      check("bp_valid",     32'(rsp_valid),  32'd1);
      check("bp_cmd_ready", 32'(cmd_ready),  32'd0);
      check("bp_result",    32'(rsp_result), 32'(held_res));
      check("bp_flags",     {rsp_zero, rsp_neg, rsp_carry}, 32'd0);
      check("bp_alu_a",     32'(alu_a),      32'(held_a));
    end
    cmd_valid = 1'b0;
    k = int'(op_count);
    rsp_ready = 1'b1;
    wait_idle();
    check("bp_count_step", 32'(op_count), 32'((k + 1) % 16));

    // Reset while in EXEC: the command must vanish without a response
    send(3'd0, 8'h11, 8'h22, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_acc = '0; cmd_model_reset();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_acc",   32'(acc),       32'd0);
    check("mid_rst_count", 32'(op_count),  32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Random commands, mixed accumulator use
    for (int i = 0; i < 20; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_idle();
    end

    // NOT 0xA5 until the 4-bit counter wraps to zero
    k = 0;
    do begin
      send(3'd2, 8'hA5, 8'h00, 1'b0, 1'b1);
      wait_idle();
      k++;
    end while (cnt_model != 4'd0 && k < 16);
    check("wrap_count", 32'(op_count), 32'd0);
    check("not_acc",    32'(acc),      32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic cmd_model_reset();
    cnt_model = '0;
    sb_q.delete();
  endtask

endmodule
`default_nettype wire
